// File: rtl/ahb_switch_debounce_pkg.sv
// ---------------------------------------------------------------------------
// ahb_switch_debounce_pkg
//   Shared definitions for the switch-debounce AHB-Lite slave.
//   - Register word offsets as decoded from HADDR[3:2].
//   - AHB transfer-type encodings used by the address-phase decoder.
// ---------------------------------------------------------------------------
package ahb_switch_debounce_pkg;

   // Register word offsets (HADDR[3:2])
   localparam logic [1:0] ADDR_STATE  = 2'b00;  // RO  debounced levels
   localparam logic [1:0] ADDR_PEND   = 2'b01;  // W1C sticky rising edges
   localparam logic [1:0] ADDR_IRQ_EN = 2'b10;  // RW  interrupt enables
   localparam logic [1:0] ADDR_RAW    = 2'b11;  // RO  synchronised inputs

   // AHB HTRANS encodings; only bit 1 matters for accepting a transfer
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // True for transfer types that carry a real access (NONSEQ/SEQ)
   function automatic logic is_active_trans(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
//   One switch input: two-flop synchroniser, hold counter and debounced
//   stable flop.
//   Ports:
//     clk     in   system clock
//     rst_n   in   asynchronous active-low reset
//     sw_in   in   raw asynchronous switch pin
//     sync    out  synchronised (undebounced) level, pin delayed two clocks
//     stable  out  debounced level
//     rise    out  high in the cycle whose clock edge moves stable 0->1
// ---------------------------------------------------------------------------
module sw_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sync,
   output logic stable,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic [CNT_W-1:0] cnt;
   logic             differs;
   logic             accept_new;

   // Two-flop synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= sw_in;
         sync <= meta;
      end
   end

   assign differs    = (sync != stable);
   assign accept_new = differs && (cnt == CNT_MAX);

   // Counter runs only while the synced level disagrees with the accepted
   // level; any agreeing cycle (a glitch ending) restarts the hold time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (!differs) begin
         cnt <= '0;
      end else if (accept_new) begin
         stable <= sync;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Combinational so the top can set PEND on the same edge stable rises
   assign rise = accept_new && sync;

endmodule

// File: rtl/ahb_switch_debounce.sv
// ---------------------------------------------------------------------------
// ahb_switch_debounce
//   Switch-bank conditioner on AHB-Lite: per-bit sync + debounce, sticky
//   rising-edge capture (PEND), interrupt enables and a registered level IRQ.
//   Ports:
//     CLK, RESET         clock, asynchronous active-low reset
//     SW_IN[WIDTH]       raw switch pins
//     HSEL..HWDATA       AHB-Lite slave inputs (HSIZE ignored, 32-bit only)
//     HRDATA             read data, combinational in the data phase
//     HREADYOUT, HRESP   tied to ready / OKAY (zero wait states)
//     SW_STABLE[WIDTH]   debounced levels
//     IRQ                |(PEND & IRQ_EN), registered
//   Register map (HADDR[3:2]): 0 STATE RO, 1 PEND W1C, 2 IRQ_EN RW, 3 RAW RO.
//   Bus handshake: an address phase is taken when HSEL & HREADY & HTRANS[1];
//   its data phase is the next cycle, where writes commit at the closing edge
//   using HWDATA and reads present HRDATA from the live register value.
// ---------------------------------------------------------------------------
module ahb_switch_debounce
   import ahb_switch_debounce_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] SW_IN,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic [2:0]       HSIZE,
   input  logic             HREADY,
   input  logic [31:0]      HWDATA,
   output logic [31:0]      HRDATA,
   output logic             HREADYOUT,
   output logic             HRESP,
   output logic [WIDTH-1:0] SW_STABLE,
   output logic             IRQ
);

   logic [WIDTH-1:0] sync_bits;
   logic [WIDTH-1:0] stable_bits;
   logic [WIDTH-1:0] rise_bits;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] irq_en;
   logic [WIDTH-1:0] pend_clr;

   logic             accept;
   logic [1:0]       addr_q;
   logic             wr_q;
   logic             wr_pend;
   logic             wr_irq_en;

   // Size is fixed at 32 bits and only HADDR[3:2] is decoded
   logic unused_bus_bits;
   assign unused_bus_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

   // ------------------------------------------------------------------
   // Per-bit conditioning
   // ------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk    (CLK),
         .rst_n  (RESET),
         .sw_in  (SW_IN[i]),
         .sync   (sync_bits[i]),
         .stable (stable_bits[i]),
         .rise   (rise_bits[i])
      );
   end

   assign SW_STABLE = stable_bits;

   // ------------------------------------------------------------------
   // AHB address phase capture
   // ------------------------------------------------------------------
   assign accept = HSEL && HREADY && is_active_trans(HTRANS);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         addr_q <= ADDR_STATE;
         wr_q   <= 1'b0;
      end else if (HREADY) begin
         // Write flag drops on any non-accepted cycle so an IDLE/BUSY or
         // deselected beat can never commit stale data.
         wr_q <= accept && HWRITE;
         if (accept) begin
            addr_q <= HADDR[3:2];
         end
      end
   end

   assign wr_pend   = wr_q && (addr_q == ADDR_PEND);
   assign wr_irq_en = wr_q && (addr_q == ADDR_IRQ_EN);
   assign pend_clr  = wr_pend ? HWDATA[WIDTH-1:0] : '0;

   // ------------------------------------------------------------------
   // PEND / IRQ_EN / IRQ
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pend   <= '0;
         irq_en <= '0;
         IRQ    <= 1'b0;
      end else begin
         // Set is OR-ed after the clear so a same-cycle rise survives W1C
         pend <= (pend & ~pend_clr) | rise_bits;
         if (wr_irq_en) begin
            irq_en <= HWDATA[WIDTH-1:0];
         end
         IRQ <= |(pend & irq_en);
      end
   end

   // ------------------------------------------------------------------
   // Read data: live register selected by the latched address
   // ------------------------------------------------------------------
   always_comb begin
      HRDATA = '0;
      case (addr_q)
         ADDR_STATE:  HRDATA[WIDTH-1:0] = stable_bits;
         ADDR_PEND:   HRDATA[WIDTH-1:0] = pend;
         ADDR_IRQ_EN: HRDATA[WIDTH-1:0] = irq_en;
         ADDR_RAW:    HRDATA[WIDTH-1:0] = sync_bits;
         default:     HRDATA = '0;
      endcase
   end

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_switch_debounce.sv
// Directed bench for ahb_switch_debounce with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that point (registered outputs) or on the falling edge (read data).
module tb_ahb_switch_debounce;
   import ahb_switch_debounce_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;
   localparam int CNT_W = 3;

   logic             CLK    = 1'b0;
   logic             RESET  = 1'b0;
   logic [WIDTH-1:0] SW_IN  = '0;
   logic             HSEL   = 1'b0;
   logic [31:0]      HADDR  = '0;
   logic [1:0]       HTRANS = 2'b00;
   logic             HWRITE = 1'b0;
   logic [2:0]       HSIZE  = 3'b010;
   logic             HREADY = 1'b1;
   logic [31:0]      HWDATA = '0;
   logic [31:0]      HRDATA;
   logic             HREADYOUT;
   logic             HRESP;
   logic [WIDTH-1:0] SW_STABLE;
   logic             IRQ;

   ahb_switch_debounce #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (CNT_W)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .SW_IN     (SW_IN),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .SW_STABLE (SW_STABLE),
      .IRQ       (IRQ)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int          tests_run = 0;
   int          fails     = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        rd_dphase = 1'b0;
   logic [31:0] mon_exp;
   string       mon_name;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic addr_phase(input logic [1:0] r, input logic wr);
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
      HWRITE = wr;
      HADDR  = {28'h0, r, 2'b00};
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0;
      HADDR  = '0;
   endtask

   task automatic expect_read(input logic [31:0] exp, input string name);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
      addr_phase(r, 1'b1);
      tick();
      bus_idle();
      HWDATA = d;
      tick();
   endtask

   task automatic ahb_read(input logic [1:0] r, input logic [31:0] exp, input string name);
      addr_phase(r, 1'b0);
      expect_read(exp, name);
      tick();
      bus_idle();
      tick();
   endtask

   // Non-accepted beat (IDLE, or NONSEQ with HSEL low) that looks like a write
   task automatic ghost_write(input logic sel, input logic [1:0] trans,
                              input logic [1:0] r, input logic [31:0] d);
      HSEL   = sel;
      HTRANS = trans;
      HWRITE = 1'b1;
      HADDR  = {28'h0, r, 2'b00};
      tick();
      bus_idle();
      HWDATA = d;
      tick();
   endtask

   // ---------------- monitor ----------------
   always @(posedge CLK) rd_dphase <= HSEL && HREADY && HTRANS[1] && !HWRITE;

   always @(negedge CLK) begin
      if (rd_dphase) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL hrdata_unexpected: got %h expected no read", HRDATA);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check(mon_name, HRDATA, mon_exp);
         end
         check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
         check("hresp", {31'b0, HRESP}, 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1 Reset with all switches high
      SW_IN = 8'hFF;
      ticks(3);
      check("rst_sw_stable", {24'b0, SW_STABLE}, 32'h0);
      check("rst_irq", {31'b0, IRQ}, 32'h0);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      check("rst_hresp", {31'b0, HRESP}, 32'h0);
      RESET = 1'b1;
      ticks(5);
      check("rst_stable_early", {24'b0, SW_STABLE}, 32'h0);
      tick();
      check("rst_stable_qual", {24'b0, SW_STABLE}, 32'hFF);
      check("rst_irq_masked", {31'b0, IRQ}, 32'h0);
      ahb_read(ADDR_PEND, 32'hFF, "rst_pend");

      // Release all, clear PEND
      SW_IN = 8'h00;
      ticks(8);
      check("fall_all", {24'b0, SW_STABLE}, 32'h0);
      ahb_write(ADDR_PEND, 32'hFF);
      ahb_read(ADDR_PEND, 32'h0, "pend_cleared");

      // 2 Three-cycle glitch on bit 0 is dropped
      SW_IN = 8'h01;
      ticks(3);
      SW_IN = 8'h00;
      ticks(10);
      check("glitch_stable", {24'b0, SW_STABLE}, 32'h0);
      ahb_read(ADDR_PEND, 32'h0, "glitch_pend");

      // 3 Rising edge with IRQ enabled, then W1C
      ahb_write(ADDR_IRQ_EN, 32'h01);
      SW_IN = 8'h01;
      ticks(5);
      check("edge_stable_early", {24'b0, SW_STABLE}, 32'h0);
      tick();
      check("edge_stable", {24'b0, SW_STABLE}, 32'h01);
      check("edge_irq_not_yet", {31'b0, IRQ}, 32'h0);
      tick();
      check("edge_irq", {31'b0, IRQ}, 32'h1);
      ahb_read(ADDR_PEND, 32'h01, "edge_pend");
      ahb_write(ADDR_PEND, 32'h01);
      check("irq_hold", {31'b0, IRQ}, 32'h1);
      tick();
      check("irq_cleared", {31'b0, IRQ}, 32'h0);

      // 4 W1C of PEND[1] lands on the edge where SW_STABLE[1] rises
      SW_IN = 8'h03;
      ticks(4);
      ahb_write(ADDR_PEND, 32'h02);
      check("collide_stable", {24'b0, SW_STABLE}, 32'h03);
      ahb_read(ADDR_PEND, 32'h02, "collide_pend");
      check("collide_irq", {31'b0, IRQ}, 32'h0);
      ahb_write(ADDR_PEND, 32'h02);
      ahb_read(ADDR_PEND, 32'h0, "w1c_pend");

      // 5 Back-to-back: read STATE, write IRQ_EN, read IRQ_EN
      addr_phase(ADDR_STATE, 1'b0);
      expect_read(32'h03, "b2b_state");
      tick();
      addr_phase(ADDR_IRQ_EN, 1'b1);
      tick();
      addr_phase(ADDR_IRQ_EN, 1'b0);
      HWDATA = 32'hA5;
      expect_read(32'hA5, "b2b_irq_en");
      tick();
      bus_idle();
      tick();
      ahb_write(ADDR_STATE, 32'hFF);
      ahb_read(ADDR_STATE, 32'h03, "state_ro");
      ahb_read(ADDR_RAW, 32'h03, "raw");
      ghost_write(1'b1, HTRANS_IDLE, ADDR_IRQ_EN, 32'h00);
      ahb_read(ADDR_IRQ_EN, 32'hA5, "idle_no_write");
      ghost_write(1'b0, HTRANS_NONSEQ, ADDR_IRQ_EN, 32'h00);
      ahb_read(ADDR_IRQ_EN, 32'hA5, "hsel0_no_write");
      ahb_write(ADDR_IRQ_EN, 32'hFFFF_FFFF);
      ahb_read(ADDR_IRQ_EN, 32'h0000_00FF, "irq_en_upper");

      // 6 Falling edge on bit 2 sets nothing
      SW_IN = 8'h07;
      ticks(8);
      check("bit2_stable", {24'b0, SW_STABLE}, 32'h07);
      check("bit2_irq", {31'b0, IRQ}, 32'h1);
      ahb_write(ADDR_PEND, 32'h04);
      tick();
      check("bit2_irq_clr", {31'b0, IRQ}, 32'h0);
      SW_IN = 8'h03;
      ticks(5);
      check("fall_early", {24'b0, SW_STABLE}, 32'h07);
      tick();
      check("fall_stable", {24'b0, SW_STABLE}, 32'h03);
      ahb_read(ADDR_PEND, 32'h0, "fall_pend");
      check("fall_irq", {31'b0, IRQ}, 32'h0);

      ticks(2);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
